// File: rtl/minimax_mem_arbiter.sv
// rtl/minimax_mem_arbiter.sv - single-port RAM arbiter for minimax fetch/data ports
// Data-first arbitration with anti-starvation, halt/exit register decode.
module minimax_mem_arbiter #(
  parameter int          PC_BITS      = 13,
  parameter int          STARVE_LIMIT = 3,
  parameter logic [31:0] HALT_ADDR    = 32'hFFFFFFFC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [PC_BITS-1:0] i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [15:0]        i_rdata,
  input  logic               d_req,
  input  logic [31:0]        d_addr,
  input  logic [3:0]         d_wmask,
  input  logic [31:0]        d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [PC_BITS-3:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic               halted,
  output logic [31:0]        exit_code
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_starve_cnt, w_starve_nxt;
  logic        r_pend_i, r_pend_d, r_pend_zero, r_hsel;
  logic [31:0] r_exit_code;

  logic w_d_in_range, w_d_is_halt, w_halt_wr, w_starved, w_run, w_d_ram, w_lsb_tie;

  // Ignored address LSBs are folded into a constant-zero term so they stay referenced.
  assign w_lsb_tie    = &{1'b0, i_addr[0], d_addr[1:0]};
  assign w_d_in_range = (d_addr[31:PC_BITS] == '0);
  assign w_d_is_halt  = (d_addr[31:2] == HALT_ADDR[31:2]);
  assign w_starved    = (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_run        = (r_state == S_RUN) && !reset;
  assign w_halt_wr    = d_gnt && w_d_is_halt && (d_wmask == 4'hF);
  assign w_d_ram      = d_gnt && w_d_in_range;

  always_comb begin
    w_state_nxt = r_state;
    d_gnt       = w_run && d_req && !(i_req && w_starved);
    i_gnt       = w_run && i_req && !d_gnt;
    if (r_state == S_RUN && w_halt_wr)
      w_state_nxt = S_HALTED;
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_req || i_gnt)
      w_starve_nxt = 4'd0;
    else if (d_gnt && !w_starved)
      w_starve_nxt = r_starve_cnt + 4'd1;
  end

  assign ram_en    = w_d_ram || i_gnt;
  assign ram_we    = w_d_ram ? d_wmask : 4'h0;
  assign ram_wdata = w_d_ram ? d_wdata : 32'h0;
  assign ram_addr  = w_d_ram ? d_addr[PC_BITS-1:2] :
                     i_gnt   ? i_addr[PC_BITS-1:2] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_starve_cnt <= 4'd0;
      r_pend_i     <= 1'b0;
      r_pend_d     <= 1'b0;
      r_pend_zero  <= 1'b0;
      r_hsel       <= 1'b0;
      r_exit_code  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_pend_i     <= i_gnt;
      r_pend_d     <= d_gnt && (d_wmask == 4'h0);
      r_pend_zero  <= d_gnt && !w_d_in_range;
      r_hsel       <= i_addr[1] | w_lsb_tie;
      if (w_halt_wr)
        r_exit_code <= d_wdata;
    end
  end

  // Returns are masked during reset so an in-flight read is discarded.
  assign i_rvalid  = r_pend_i && !reset;
  assign d_rvalid  = r_pend_d && !reset;
  assign i_rdata   = !i_rvalid ? 16'h0 : (r_hsel ? ram_rdata[31:16] : ram_rdata[15:0]);
  assign d_rdata   = (d_rvalid && !r_pend_zero) ? ram_rdata : 32'h0;
  assign halted    = (r_state == S_HALTED) && !reset;
  assign exit_code = reset ? 32'h0 : r_exit_code;

endmodule

// File: tb/tb_minimax_mem_arbiter.sv
// tb/tb_minimax_mem_arbiter.sv - directed self-checking bench for minimax_mem_arbiter
module tb_minimax_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [12:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        halted;
  logic [31:0] exit_code;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  minimax_mem_arbiter #(.PC_BITS(13), .STARVE_LIMIT(3), .HALT_ADDR(32'hFFFFFFFC)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .halted(halted), .exit_code(exit_code)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] exp_d_seq;

  initial begin
    mem[0]  = 32'hBEEF1234;
    reset   = 1'b1;
    i_req   = 1'b0; i_addr = '0;
    d_req   = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
    tick; tick;
    chk("rst_gnt",    {30'd0, i_gnt, d_gnt}, 32'h0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
    chk("rst_ram_en", ram_en, 32'h0);
    chk("rst_halted", halted, 32'h0);
    chk("rst_exit",   exit_code, 32'h0);
    reset = 1'b0;

    // Fetch upper and lower halfwords of RAM[0]
    i_req = 1'b1; i_addr = 13'h002;
    #1;
    chk("t1_i_gnt", i_gnt, 32'h1);
    chk("t1_d_gnt", d_gnt, 32'h0);
    chk("t1_ram",   {ram_en, ram_we, 16'd0, ram_addr}, {1'b1, 4'h0, 16'd0, 11'd0});
    tick;
    i_req = 1'b1; i_addr = 13'h000;
    #1;
    chk("t1_rvalid_hi", i_rvalid, 32'h1);
    chk("t1_rdata_hi",  i_rdata, 32'hBEEF);
    tick;
    i_req = 1'b0;
    #1;
    chk("t1_rdata_lo", i_rdata, 32'h1234);

    // Write then read back same word
    tick;
    d_req = 1'b1; d_addr = 32'h10; d_wmask = 4'hF; d_wdata = 32'hCAFEF00D;
    #1;
    chk("t2_wr_gnt",  d_gnt, 32'h1);
    chk("t2_wr_ram",  {ram_en, ram_we, 16'd0, ram_addr}, {1'b1, 4'hF, 16'd0, 11'd4});
    chk("t2_wr_data", ram_wdata, 32'hCAFEF00D);
    tick;
    d_wmask = 4'h0;
    #1;
    chk("t2_wr_no_rvalid", d_rvalid, 32'h0);
    chk("t2_rd_gnt",       d_gnt, 32'h1);
    tick;
    d_req = 1'b0;
    #1;
    chk("t2_rd_rvalid", d_rvalid, 32'h1);
    chk("t2_rd_data",   d_rdata, 32'hCAFEF00D);

    // Contention: D,D,D,I,D,D
    tick;
    exp_d_seq = 6'b110111;
    i_req = 1'b1; i_addr = 13'h000;
    d_req = 1'b1; d_addr = 32'h10; d_wmask = 4'h0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_d_gnt%0d", k), d_gnt, {31'd0, exp_d_seq[k]});
      chk($sformatf("t3_i_gnt%0d", k), i_gnt, {31'd0, ~exp_d_seq[k]});
      tick;
    end
    i_req = 1'b0; d_req = 1'b0;

    // Out-of-range read returns zero
    tick;
    d_req = 1'b1; d_addr = 32'h00004000; d_wmask = 4'h0;
    #1;
    chk("t5_gnt",    d_gnt, 32'h1);
    chk("t5_ram_en", ram_en, 32'h0);
    tick;
    d_req = 1'b0;
    #1;
    chk("t5_rvalid", d_rvalid, 32'h1);
    chk("t5_rdata",  d_rdata, 32'h0);

    // Partial-mask halt write is ignored
    tick;
    d_req = 1'b1; d_addr = 32'hFFFFFFFC; d_wmask = 4'h3; d_wdata = 32'h5;
    #1;
    chk("tp_gnt",    d_gnt, 32'h1);
    chk("tp_ram_en", ram_en, 32'h0);
    tick;
    d_req = 1'b0;
    #1;
    chk("tp_halted", halted, 32'h0);
    chk("tp_rvalid", d_rvalid, 32'h0);

    // Full halt write
    tick;
    d_req = 1'b1; d_addr = 32'hFFFFFFFC; d_wmask = 4'hF; d_wdata = 32'h7;
    #1;
    chk("t4_gnt",    d_gnt, 32'h1);
    chk("t4_ram_en", ram_en, 32'h0);
    tick;
    d_addr = 32'h10; d_wmask = 4'h0; i_req = 1'b1;
    #1;
    chk("t4_halted", halted, 32'h1);
    chk("t4_exit",   exit_code, 32'h7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_blocked%0d", k), {29'd0, i_gnt, d_gnt, ram_en}, 32'h0);
      tick;
      #1;
    end

    // Reset clears halt, then reset right after a granted read
    reset = 1'b1;
    tick;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b1; d_addr = 32'h10; d_wmask = 4'h0;
    #1;
    chk("t6_halted_clr", halted, 32'h0);
    chk("t6_exit_clr",   exit_code, 32'h0);
    chk("t6_rd_gnt",     d_gnt, 32'h1);
    tick;
    reset = 1'b1; d_req = 1'b0;
    #1;
    chk("t6_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'h0);
    chk("t6_rdata",     d_rdata, 32'h0);
    chk("t6_ram_en",    ram_en, 32'h0);
    chk("t6_halted",    halted, 32'h0);
    tick;
    reset = 1'b0;
    #1;
    chk("t6_post_rvalid", d_rvalid, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
